// File: rtl/host_descriptor_transmit_pkg.sv
// Shared host-path constants: descriptor field positions, inter-frame gap
// length and the transmit FSM state encoding.
package host_descriptor_transmit_pkg;

  localparam int DESC_W        = 22;
  localparam int DESC_BUFID_LSB = 0;
  localparam int DESC_BUFID_MSB = 8;
  localparam int DESC_LEN_LSB   = 9;
  localparam int DESC_LEN_MSB   = 19;
  localparam int DESC_QID_LSB   = 20;
  localparam int DESC_QID_MSB   = 21;

  localparam logic [3:0] IFG_CYCLES = 4'd12;

  typedef enum logic [2:0] {
    IDLE_S     = 3'd0,
    READ_S     = 3'd1,
    TRANSMIT_S = 3'd2,
    IFG_S      = 3'd3,
    RELEASE_S  = 3'd4
  } state_e;

endpackage

// File: rtl/host_descriptor_transmit_serializer.sv
// 32-to-8 serializer: emits a loaded word MSB byte first and flags the final
// byte of the packet, dropping any bytes of the last word beyond the length.
module host_word_serializer (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clear,
  input  logic        i_load,
  input  logic [31:0] iv_word,
  input  logic [10:0] iv_last_idx,
  output logic        o_valid,
  output logic [7:0]  ov_byte,
  output logic        o_last,
  output logic        o_third
);

  logic [31:0] shift_q, shift_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [10:0] bytes_q, bytes_d;

  assign o_valid = (cnt_q != 3'd0);
  assign ov_byte = o_valid ? shift_q[31:24] : 8'd0;
  assign o_last  = o_valid && (bytes_q == iv_last_idx);
  // Third byte of a word: the slot in which the next word must be requested.
  assign o_third = (cnt_q == 3'd2);

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    bytes_d = bytes_q;
    if (i_clear) begin
      shift_d = 32'd0;
      cnt_d   = 3'd0;
      bytes_d = 11'd0;
    end else begin
      if (o_valid) begin
        shift_d = {shift_q[23:0], 8'd0};
        cnt_d   = o_last ? 3'd0 : cnt_q - 3'd1;
        bytes_d = bytes_q + 11'd1;
      end
      if (i_load) begin
        shift_d = iv_word;
        cnt_d   = 3'd4;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      shift_q <= 32'd0;
      cnt_q   <= 3'd0;
      bytes_q <= 11'd0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      bytes_q <= bytes_d;
    end
  end

endmodule

// File: rtl/host_descriptor_transmit.sv
// Host transmit path: takes a buffer descriptor, streams the packet bytes from
// the packet buffer to the MAC, waits the inter-frame gap and frees the buffer.
module host_descriptor_transmit
  import host_descriptor_transmit_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DESC_W-1:0] iv_descriptor,
  input  logic              i_descriptor_wr,
  output logic              o_descriptor_ready,
  output logic              o_pkt_rd,
  output logic [17:0]       ov_pkt_raddr,
  input  logic [31:0]       iv_pkt_rdata,
  output logic [7:0]        ov_data,
  output logic              o_data_wr,
  output logic              o_data_last,
  output logic [8:0]        ov_bufid_free,
  output logic              o_bufid_free_wr,
  output logic              o_descriptor_drop,
  output state_e            ov_dbg_state
);

  state_e      state_q, state_d;
  logic [8:0]  bufid_q, bufid_d;
  logic [10:0] len_q, len_d;
  logic [8:0]  word_q, word_d;
  logic [3:0]  ifg_q, ifg_d;
  logic        rd_q;
  logic        drop_q;

  logic        pkt_rd;
  logic [8:0]  rd_word;
  logic        free_wr;
  logic [10:0] len_m1;
  logic [8:0]  last_word;
  logic        ser_valid, ser_last, ser_third;
  logic [7:0]  ser_byte;
  logic        unused_qid;

  assign unused_qid = ^iv_descriptor[DESC_QID_MSB:DESC_QID_LSB];
  assign len_m1     = len_q - 11'd1;
  assign last_word  = len_m1[10:2];

  always_comb begin
    state_d = state_q;
    bufid_d = bufid_q;
    len_d   = len_q;
    word_d  = word_q;
    ifg_d   = ifg_q;
    pkt_rd  = 1'b0;
    rd_word = word_q;
    free_wr = 1'b0;
    case (state_q)
      IDLE_S: begin
        if (i_descriptor_wr) begin
          bufid_d = iv_descriptor[DESC_BUFID_MSB:DESC_BUFID_LSB];
          len_d   = iv_descriptor[DESC_LEN_MSB:DESC_LEN_LSB];
          word_d  = 9'd0;
          state_d = (len_d == 11'd0) ? RELEASE_S : READ_S;
        end
      end
      READ_S: begin
        pkt_rd  = 1'b1;
        state_d = TRANSMIT_S;
      end
      TRANSMIT_S: begin
        // Prefetch so the next word lands exactly as the current one drains.
        if (ser_third && (word_q != last_word)) begin
          pkt_rd  = 1'b1;
          rd_word = word_q + 9'd1;
          word_d  = rd_word;
        end
        if (ser_last) begin
          ifg_d   = 4'd0;
          state_d = IFG_S;
        end
      end
      IFG_S: begin
        ifg_d = ifg_q + 4'd1;
        if (ifg_q == IFG_CYCLES - 4'd1) state_d = RELEASE_S;
      end
      RELEASE_S: begin
        free_wr = 1'b1;
        state_d = IDLE_S;
      end
      default: state_d = IDLE_S;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE_S;
      bufid_q <= 9'd0;
      len_q   <= 11'd0;
      word_q  <= 9'd0;
      ifg_q   <= 4'd0;
      rd_q    <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bufid_q <= bufid_d;
      len_q   <= len_d;
      word_q  <= word_d;
      ifg_q   <= ifg_d;
      rd_q    <= pkt_rd;
      drop_q  <= i_descriptor_wr && (state_q != IDLE_S);
    end
  end

  host_word_serializer u_serializer (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_clear     (state_q == IDLE_S),
    .i_load      (rd_q),
    .iv_word     (iv_pkt_rdata),
    .iv_last_idx (len_m1),
    .o_valid     (ser_valid),
    .ov_byte     (ser_byte),
    .o_last      (ser_last),
    .o_third     (ser_third)
  );

  assign o_pkt_rd           = pkt_rd;
  assign ov_pkt_raddr       = pkt_rd ? {bufid_q, rd_word} : 18'd0;
  assign o_data_wr          = ser_valid;
  assign ov_data            = ser_byte;
  assign o_data_last        = ser_last;
  assign o_bufid_free_wr    = free_wr;
  assign ov_bufid_free      = free_wr ? bufid_q : 9'd0;
  assign o_descriptor_ready = free_wr;
  assign o_descriptor_drop  = drop_q;
  assign ov_dbg_state       = state_q;

endmodule

// File: doc/host_descriptor_transmit.md
HOST_DESCRIPTOR_TRANSMIT -- requirements
Module: host_descriptor_transmit

Interface
REQ-001 SHALL have a single clock and a synchronous, active-low reset: i_clk  input  1  clock; i_rst_n  input  1  synchronous active-low reset.
REQ-002 SHALL provide iv_descriptor  input  22  descriptor: [8:0] bufid, [19:9] packet length in bytes, [21:20] queue id (unused).
REQ-003 SHALL provide i_descriptor_wr  input  1  one-cycle strobe marking iv_descriptor valid.
REQ-004 SHALL provide o_descriptor_ready  output  1  one-cycle pulse signalling the current descriptor is fully consumed.
REQ-005 SHALL provide o_pkt_rd  output  1  packet-buffer read strobe, and ov_pkt_raddr  output  18  address {bufid[8:0], word[8:0]}.
REQ-006 SHALL provide iv_pkt_rdata  input  32  read data, valid exactly 1 cycle after o_pkt_rd.
REQ-007 SHALL provide ov_data  output  8  byte to host MAC, o_data_wr  output  1  byte valid, and o_data_last  output  1  final byte of packet.
REQ-008 SHALL provide ov_bufid_free  output  9  released bufid, and o_bufid_free_wr  output  1  release strobe.
REQ-009 SHALL provide o_descriptor_drop  output  1  one-cycle pulse when a descriptor is discarded.

Function
REQ-010 SHALL implement states IDLE_S, READ_S, TRANSMIT_S, IFG_S and RELEASE_S.
REQ-011 IDLE_S: on i_descriptor_wr with length≠0, SHALL latch bufid and length and go to READ_S.
REQ-012 IDLE_S: on i_descriptor_wr with length=0, SHALL go directly to RELEASE_S with no o_pkt_rd and no o_data_wr.
REQ-013 Words SHALL be read from word 0 upward, ceil(length/4) words per packet.
REQ-014 Each word SHALL be serialized MSB byte first ([31:24] first); excess bytes of the last word SHALL NOT be emitted.
REQ-015 Latency: with descriptor sampled at edge T, o_pkt_rd (word 0) SHALL be high in cycle T+1 and the first o_data_wr in cycle T+3.
REQ-016 Bytes SHALL be emitted on consecutive cycles with no gaps: the next word is prefetched while the third byte of the current word is output.
REQ-017 o_data_last SHALL be high only together with the o_data_wr of byte number length.
REQ-018 After the last byte, SHALL spend exactly 12 cycles in IFG_S with o_data_wr=0.
REQ-019 RELEASE_S SHALL last one cycle and pulse o_bufid_free_wr with ov_bufid_free=bufid and o_descriptor_ready, both in the same cycle, then return to IDLE_S.
REQ-020 An i_descriptor_wr that arrives in any state other than IDLE_S SHALL be ignored, SHALL pulse o_descriptor_drop in the next cycle, and SHALL NOT disturb the packet in progress.
REQ-021 ov_data, ov_pkt_raddr and ov_bufid_free SHALL be 0 whenever their strobe is low.
REQ-022 The word counter SHALL be 9 bits and the byte counter 11 bits, with no wrap within a packet; maximum length is 2047 bytes (512 words).

Reset
REQ-023 While i_rst_n=0 at a clock edge, all outputs SHALL be 0 and the state SHALL be IDLE_S.
REQ-024 Reset asserted mid-packet SHALL abort the packet with no o_data_last, no bufid release and no ready pulse.

Structure
REQ-025 Descriptor field positions, IFG length (12) and the state encodings SHALL be constants in a shared host-path package.
REQ-026 The 32-to-8 serializer (shift register, byte count, last flag) SHALL be one sub-module, host_word_serializer; everything else SHALL be flat.

Verification
REQ-027 Descriptor bufid=5, length=64 -> 16 reads at addresses 0x00A00..0x00A0F; 64 contiguous bytes starting at T+3; last byte flagged; 12 idle cycles; release of bufid 5 together with a ready pulse.
REQ-028 length=61 -> 16 words read; 61 bytes output; last word's bytes [23:0] suppressed; o_data_last on byte 61.
REQ-029 length=0, bufid=9 -> no reads; release of bufid 9 and ready pulse in cycle T+1.
REQ-030 Second i_descriptor_wr mid-packet -> o_descriptor_drop pulse; first packet's byte stream unchanged; exactly one release.
REQ-031 Reset asserted at byte 20 of a 100-byte packet -> all outputs 0, no release; a following descriptor is processed normally.
REQ-032 length=2047, bufid=511 -> 512 reads ending at address 0x3FFFF; 2047 bytes output; no counter wrap.
